// File: rtl/act_requant_if.sv
// act_requant_if: input sample stream and next-layer imem write port
interface act_requant_if #(
    parameter int IN_WIDTH   = 14,
    parameter int OUT_WIDTH  = 6,
    parameter int ADDR_WIDTH = 6
);
    logic                        in_wr;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic        [ADDR_WIDTH-1:0] omem_addr;
    logic                        omem_wr;
    logic        [OUT_WIDTH-1:0] omem_data;
    modport master (output in_wr, in_data, input omem_addr, omem_wr, omem_data);
    modport slave (input in_wr, in_data, output omem_addr, omem_wr, omem_data);
endinterface

// File: rtl/act_requant.sv
// act_requant: round/shift/clamp signed results into 6-bit imem words per frame; ACT_RELU_EN selects ReLU clamp
module act_requant #(
    parameter int IN_WIDTH   = 14,
    parameter int OUT_WIDTH  = 6,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int SHIFT      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sat_cnt,
    act_requant_if.slave          bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int TW = IN_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic signed [TW-1:0] BIAS = TW'(SHIFT > 0 ? 1 << (SHIFT - 1) : 0);
`ifdef ACT_RELU_EN
    localparam logic signed [TW-1:0] HI = TW'((1 << OUT_WIDTH) - 1);
    localparam logic signed [TW-1:0] LO = '0;
`else
    localparam logic signed [TW-1:0] HI = TW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [TW-1:0] LO = TW'(-(1 << (OUT_WIDTH - 1)));
`endif
    state_t                 state_q, state_d;
    logic [CW-1:0]          in_cnt_q, in_cnt_d, sat_cnt_q, sat_cnt_d;
    logic signed [TW-1:0]   t_q, t_d;
    logic                   v_q, v_d, omem_wr_q, omem_wr_d;
    logic [OUT_WIDTH-1:0]   omem_data_q, omem_data_d;
    logic [ADDR_WIDTH-1:0]  omem_addr_q, omem_addr_d;
    logic                   go, acc, hi, lo;
    always_comb begin
        go = state_q == IDLE && start;
        acc = state_q == RUN && bus.in_wr;
        t_d = (TW'(bus.in_data) + BIAS) >>> SHIFT;
        v_d = acc;
        hi = t_q > HI;
        lo = t_q < LO;
        in_cnt_d = go ? '0 : in_cnt_q + CW'(acc);
        omem_wr_d = v_q;
        omem_data_d = !v_q ? omem_data_q : hi ? HI[OUT_WIDTH-1:0] : lo ? LO[OUT_WIDTH-1:0] : t_q[OUT_WIDTH-1:0];
        omem_addr_d = go ? '0 : omem_addr_q + ADDR_WIDTH'(omem_wr_q);
        sat_cnt_d = go ? '0 : sat_cnt_q + CW'(v_q && (hi || lo) && !(&sat_cnt_q));
        // DRAIN ends once the stage-1 slot is empty and the final word is on the port
        state_d = go ? RUN
                : (acc && in_cnt_q == CW'(DEPTH - 1)) ? DRAIN
                : (state_q == DRAIN && !v_q && omem_wr_q) ? DONE
                : state_q == DONE ? IDLE
                : state_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            sat_cnt_q   <= '0;
            t_q         <= '0;
            v_q         <= 1'b0;
            omem_wr_q   <= 1'b0;
            omem_data_q <= '0;
            omem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            t_q         <= t_d;
            v_q         <= v_d;
            omem_wr_q   <= omem_wr_d;
            omem_data_q <= omem_data_d;
            omem_addr_q <= omem_addr_d;
        end
    end
    assign busy          = state_q == RUN || state_q == DRAIN;
    assign done          = state_q == DONE;
    assign sat_cnt       = sat_cnt_q;
    assign bus.omem_wr   = omem_wr_q;
    assign bus.omem_data = omem_data_q;
    assign bus.omem_addr = omem_addr_q;
endmodule
